// File: rtl/click_pkg.sv
// rtl/click_pkg.sv - shared types for the click demux slice
package click_pkg;

  // One bit of 2-phase handshake signalling
  typedef logic phase_t;

  // Demux controller states
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/click_demux_2_if.sv
// rtl/click_demux_2_if.sv - 2-phase click channel interfaces (with and without data)
interface ifc_click #(
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  ack;
  logic [DATA_WIDTH-1:0] data;

  modport in  (input req, input data, output ack);
  modport out (output req, output data, input ack);
endinterface

interface ifc_click_nodata;
  logic req;
  logic ack;

  modport in  (input req, output ack);
  modport out (output req, input ack);
endinterface

// File: rtl/click_sync2.sv
// rtl/click_sync2.sv - 1-bit two-flop synchronizer with configurable reset value
module click_sync2
  import click_pkg::*;
#(
  parameter phase_t RST_VAL = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  phase_t d,
  output phase_t q
);

  phase_t s1;
  phase_t s2;

  // Two-stage capture; both stages start at the channel's initial phase
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/click_demux_2.sv
// rtl/click_demux_2.sv - 2-phase click demux, one input token routed to outB or outC; CLICK_DEMUX_SYNC_EN adds input synchronizers
module click_demux_2
  import click_pkg::*;
#(
  parameter int     DATA_WIDTH     = 8,
  parameter phase_t PHASE_INIT_A   = 1'b0,
  parameter phase_t PHASE_INIT_B   = 1'b0,
  parameter phase_t PHASE_INIT_C   = 1'b0,
  parameter phase_t PHASE_INIT_SEL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  ifc_click.in            inA,
  ifc_click_nodata.in     sel,
  input  logic            sel_data,
  ifc_click.out           outB,
  ifc_click.out           outC
);

  // Handshake inputs as seen by the controller (raw or synchronized)
  phase_t a_req_s;
  phase_t sel_req_s;
  phase_t b_ack_s;
  phase_t c_ack_s;

`ifdef CLICK_DEMUX_SYNC_EN
  click_sync2 #(.RST_VAL(PHASE_INIT_A))   u_sync_a   (.clk(clk), .rst(rst), .d(inA.req),  .q(a_req_s));
  click_sync2 #(.RST_VAL(PHASE_INIT_SEL)) u_sync_sel (.clk(clk), .rst(rst), .d(sel.req),  .q(sel_req_s));
  click_sync2 #(.RST_VAL(PHASE_INIT_B))   u_sync_b   (.clk(clk), .rst(rst), .d(outB.ack), .q(b_ack_s));
  click_sync2 #(.RST_VAL(PHASE_INIT_C))   u_sync_c   (.clk(clk), .rst(rst), .d(outC.ack), .q(c_ack_s));
`else
  assign a_req_s   = inA.req;
  assign sel_req_s = sel.req;
  assign b_ack_s   = outB.ack;
  assign c_ack_s   = outC.ack;
`endif

  state_t                state_q, state_n;
  phase_t                a_ack_q, a_ack_n;
  phase_t                sel_ack_q, sel_ack_n;
  phase_t                b_req_q, b_req_n;
  phase_t                c_req_q, c_req_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  route_q, route_n;

  logic a_pending;
  logic sel_pending;
  logic out_done;

  assign a_pending   = (a_req_s != a_ack_q);
  assign sel_pending = (sel_req_s != sel_ack_q);
  // Only the output chosen for the current token can complete it
  assign out_done    = route_q ? (b_ack_s == b_req_q) : (c_ack_s == c_req_q);

  // State and phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_ack_q   <= PHASE_INIT_A;
      sel_ack_q <= PHASE_INIT_SEL;
      b_req_q   <= PHASE_INIT_B;
      c_req_q   <= PHASE_INIT_C;
      data_q    <= '0;
      route_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      a_ack_q   <= a_ack_n;
      sel_ack_q <= sel_ack_n;
      b_req_q   <= b_req_n;
      c_req_q   <= c_req_n;
      data_q    <= data_n;
      route_q   <= route_n;
    end
  end

  // Join both input tokens, fire one output, then ack both inputs when it returns
  always_comb begin
    state_n   = state_q;
    a_ack_n   = a_ack_q;
    sel_ack_n = sel_ack_q;
    b_req_n   = b_req_q;
    c_req_n   = c_req_q;
    data_n    = data_q;
    route_n   = route_q;
    case (state_q)
      IDLE: begin
        if (a_pending && sel_pending) begin
          data_n  = inA.data;
          route_n = sel_data;
          if (sel_data) begin
            b_req_n = ~b_req_q;
          end else begin
            c_req_n = ~c_req_q;
          end
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (out_done) begin
          a_ack_n   = ~a_ack_q;
          sel_ack_n = ~sel_ack_q;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign inA.ack   = a_ack_q;
  assign sel.ack   = sel_ack_q;
  assign outB.req  = b_req_q;
  assign outC.req  = c_req_q;
  assign outB.data = data_q;
  assign outC.data = data_q;

endmodule

// File: tb/tb_click_demux_2.sv
// tb/tb_click_demux_2.sv - randomized and directed bench for click_demux_2 with a token-count reference model
module tb_click_demux_2;
  import click_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst2;
  logic sel_data;
  logic sel_data2;

  ifc_click #(8) a_if ();
  ifc_click #(8) b_if ();
  ifc_click #(8) c_if ();
  ifc_click_nodata s_if ();
  ifc_click #(8) a2_if ();
  ifc_click #(8) b2_if ();
  ifc_click #(8) c2_if ();
  ifc_click_nodata s2_if ();

  click_demux_2 #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .inA(a_if), .sel(s_if), .sel_data(sel_data),
    .outB(b_if), .outC(c_if)
  );

  click_demux_2 #(
    .DATA_WIDTH(8), .PHASE_INIT_A(1'b0), .PHASE_INIT_B(1'b1),
    .PHASE_INIT_C(1'b0), .PHASE_INIT_SEL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst2), .inA(a2_if), .sel(s2_if), .sel_data(sel_data2),
    .outB(b2_if), .outC(c2_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Token-level model: output phases follow how many tokens went each way,
  // input ack phases follow how many tokens completed.
  int         n_acc, n_done, n_b, n_c;
  logic       m_sel;
  logic [7:0] m_data;
  logic       ar, sr, ba, ca;
  logic       pa1, pa2, ps1, ps2, pb1, pb2, pc1, pc2;
  bit         model_on = 0;
  logic       e_a_ack, e_s_ack, e_b_req, e_c_req;

  always @(posedge clk) begin
`ifdef CLICK_DEMUX_SYNC_EN
    ar = pa2; sr = ps2; ba = pb2; ca = pc2;
`else
    ar = a_if.req; sr = s_if.req; ba = b_if.ack; ca = c_if.ack;
`endif
    e_a_ack = logic'(n_done % 2);
    e_s_ack = logic'(n_done % 2);
    e_b_req = logic'(n_b % 2);
    e_c_req = logic'(n_c % 2);
    if (rst) begin
      n_acc = 0; n_done = 0; n_b = 0; n_c = 0;
      m_sel = 1'b0; m_data = 8'h00;
      pa1 = 0; pa2 = 0; ps1 = 0; ps2 = 0; pb1 = 0; pb2 = 0; pc1 = 0; pc2 = 0;
    end else begin
      if (n_acc == n_done) begin
        if (ar != e_a_ack && sr != e_s_ack) begin
          n_acc++;
          m_sel = sel_data;
          m_data = a_if.data;
          if (m_sel) n_b++;
          else n_c++;
        end
      end else if (m_sel ? (ba == e_b_req) : (ca == e_c_req)) begin
        n_done++;
      end
      pa2 = pa1; pa1 = a_if.req;
      ps2 = ps1; ps1 = s_if.req;
      pb2 = pb1; pb1 = b_if.ack;
      pc2 = pc1; pc1 = c_if.ack;
    end
    #1;
    if (model_on) begin
      check("model_a_ack", a_if.ack, logic'(n_done % 2));
      check("model_sel_ack", s_if.ack, logic'(n_done % 2));
      check("model_b_req", b_if.req, logic'(n_b % 2));
      check("model_c_req", c_if.req, logic'(n_c % 2));
      check("model_b_data", b_if.data, m_data);
      check("model_c_data", c_if.data, m_data);
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    a_if.req = 0; a_if.data = 0; s_if.req = 0; sel_data = 0; b_if.ack = 0; c_if.ack = 0;
    a2_if.req = 0; a2_if.data = 0; s2_if.req = 0; sel_data2 = 0; b2_if.ack = 1; c2_if.ack = 0;
    repeat (2) edge1();
    model_on = 1;
    check("reset_a_ack", a_if.ack, 0);
    check("reset_sel_ack", s_if.ack, 0);
    check("reset_b_req", b_if.req, 0);
    check("reset_c_req", c_if.req, 0);
    check("reset_b_data", b_if.data, 0);
    check("reset_b2_req_init1", b2_if.req, 1);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

`ifndef CLICK_DEMUX_SYNC_EN
    @(negedge clk);
    a_if.data = 8'hA5; a_if.req = 1; s_if.req = 1; sel_data = 1;
    edge1();
    check("fwd_b_req", b_if.req, 1);
    check("fwd_b_data", b_if.data, 8'hA5);
    check("fwd_c_req", c_if.req, 0);
    check("fwd_no_early_ack", a_if.ack, 0);
    @(negedge clk);
    b_if.ack = 1;
    edge1();
    check("ack_a", a_if.ack, 1);
    check("ack_sel", s_if.ack, 1);

    @(negedge clk);
    a_if.data = 8'h3C; a_if.req = 0; s_if.req = 0; sel_data = 0;
    edge1();
    check("route_c_req", c_if.req, 1);
    check("route_b_unchanged", b_if.req, 1);
    check("route_c_data", c_if.data, 8'h3C);
    @(negedge clk);
    sel_data = 1; a_if.data = 8'hFF;
    edge1(); edge1();
    check("wait_b_req", b_if.req, 1);
    check("wait_c_req", c_if.req, 1);
    check("wait_data_held", c_if.data, 8'h3C);
    check("wait_no_ack", a_if.ack, 1);
    @(negedge clk);
    c_if.ack = 1;
    edge1();
    check("ack_c_a", a_if.ack, 0);
    check("ack_c_sel", s_if.ack, 0);

    @(negedge clk);
    s_if.req = 1; sel_data = 0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      check("hold_c_req", c_if.req, 1);
      check("hold_b_req", b_if.req, 1);
      check("hold_sel_ack", s_if.ack, 0);
    end
    @(negedge clk);
    a_if.data = 8'h5A; a_if.req = 1;
    edge1();
    check("join_c_req", c_if.req, 0);
    check("join_c_data", c_if.data, 8'h5A);
    @(negedge clk);
    c_if.ack = 0;
    edge1();
    check("join_ack", a_if.ack, 1);
`else
    @(negedge clk);
    a_if.data = 8'hA5; a_if.req = 1; s_if.req = 1; sel_data = 1;
    edge1(); check("sync_fwd_e1", b_if.req, 0);
    edge1(); check("sync_fwd_e2", b_if.req, 0);
    edge1(); check("sync_fwd_e3", b_if.req, 1);
    check("sync_fwd_data", b_if.data, 8'hA5);
    @(negedge clk);
    b_if.ack = 1;
    edge1(); check("sync_ack_e1", a_if.ack, 0);
    edge1(); check("sync_ack_e2", a_if.ack, 0);
    edge1(); check("sync_ack_e3", a_if.ack, 1);
    check("sync_ack_sel", s_if.ack, 1);
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (a_if.req == a_if.ack && $urandom_range(0, 2) == 0) begin
        a_if.req = ~a_if.req;
        a_if.data = 8'($urandom);
      end
      if (s_if.req == s_if.ack && $urandom_range(0, 2) == 0) begin
        s_if.req = ~s_if.req;
        sel_data = 1'($urandom_range(0, 1));
      end
      if (b_if.req != b_if.ack && $urandom_range(0, 1) == 0) b_if.ack = b_if.req;
      if (c_if.req != c_if.ack && $urandom_range(0, 1) == 0) c_if.ack = c_if.req;
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    a2_if.data = 8'h77; a2_if.req = 1; s2_if.req = 1; sel_data2 = 1;
    repeat (4) edge1();
    check("abandon_b2_toggled", b2_if.req, 0);
    check("abandon_a2_waiting", a2_if.ack, 0);
    @(negedge clk);
    rst2 = 1'b1; a2_if.req = 0; s2_if.req = 0;
    edge1();
    check("abandon_rst_b2_req", b2_if.req, 1);
    check("abandon_rst_a2_ack", a2_if.ack, 0);
    check("abandon_rst_data", b2_if.data, 0);
    @(negedge clk);
    rst2 = 1'b0;
    repeat (4) edge1();
    check("abandon_no_a_ack", a2_if.ack, 0);
    check("abandon_no_sel_ack", s2_if.ack, 0);
    check("abandon_b2_idle", b2_if.req, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
